// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the counter read-back path
// Purpose: channel count, default count width, read-channel code for the
//          status word and the bit positions of its three fields.
// Ports: none (package).
package counter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_CH        = 3;

  localparam logic [1:0] RD_CH_STATUS = 2'h3;

  localparam int ST_OUT_LSB    = 0;
  localparam int ST_LAT_LSB    = 4;
  localparam int ST_STICKY_LSB = 8;

endpackage

// File: rtl/counter_rd_chan.sv
// rtl/counter_rd_chan.sv - per-channel latch snapshot and sticky OUT-edge state
// Purpose: holds one channel's latched snapshot, latched flag, previous OUT
//          level and sticky rising-edge flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cnt          live counter, [WIDTH] = OUT level
//   latch        latch command aimed at this channel
//   rd_hit       count read of this channel this cycle
//   status_clr   status-word read this cycle (clears sticky)
//   value        snapshot while latched, otherwise live count
//   latched      snapshot held, waiting to be read
//   out          current OUT level
//   sticky       registered sticky OUT rising-edge flag
//   sticky_next  value sticky takes at the next edge
module counter_rd_chan
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   cnt,
  input  logic             latch,
  input  logic             rd_hit,
  input  logic             status_clr,
  output logic [WIDTH-1:0] value,
  output logic             latched,
  output logic             out,
  output logic             sticky,
  output logic             sticky_next
);

  logic [WIDTH-1:0] lat_val;
  logic             prev_out;

  assign out   = cnt[WIDTH];
  assign value = latched ? lat_val : cnt[WIDTH-1:0];

  // A fresh edge sets the flag even in the cycle a status read clears it.
  assign sticky_next = (sticky & ~status_clr) | (out & ~prev_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_val  <= '0;
      latched  <= 1'b0;
      prev_out <= 1'b1;  // OUT already high at release is not an edge
      sticky   <= 1'b0;
    end else begin
      prev_out <= out;
      sticky   <= sticky_next;
      // Reading a held snapshot releases it and swallows a coincident latch.
      // With nothing held, a coincident latch captures the value being read.
      if (rd_hit && latched) begin
        latched <= 1'b0;
      end else if (latch && !latched) begin
        lat_val <= cnt[WIDTH-1:0];
        latched <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_readback.sv
// rtl/counter_readback.sv - CPU read path for the three-channel down-counter block
// Purpose: latched/live count read-back, status word, sticky OUT rising edges,
//          optional interrupt (macro COUNTER_RD_IRQ_EN).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cnt0..cnt2       live counters, [WIDTH] = channel OUT
//   latch_we         latch command strobe
//   latch_mask       channels to latch, bit i = channel i
//   rd_en, rd_ch     read request; rd_ch 0..2 = count, 3 = status word
//   rd_data          read data, valid while rd_valid = 1
//   rd_valid         one-cycle pulse one clock after rd_en
//   irq_mask, irq    sticky interrupt enable/output (COUNTER_RD_IRQ_EN only)
module counter_readback
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WIDTH:0] cnt0,
  input  logic [WIDTH:0] cnt1,
  input  logic [WIDTH:0] cnt2,
  input  logic           latch_we,
  input  logic [2:0]     latch_mask,
  input  logic           rd_en,
  input  logic [1:0]     rd_ch,
  output logic [31:0]    rd_data,
  output logic           rd_valid
`ifdef COUNTER_RD_IRQ_EN
  ,
  input  logic [2:0]     irq_mask,
  output logic           irq
`endif
);

  logic [WIDTH:0]    cnt_arr [NUM_CH];
  logic [WIDTH-1:0]  value   [NUM_CH];
  logic [NUM_CH-1:0] latched;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] sticky;
  logic [NUM_CH-1:0] sticky_next;
  logic              status_clr;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;

  assign cnt_arr[0] = cnt0;
  assign cnt_arr[1] = cnt1;
  assign cnt_arr[2] = cnt2;

  assign status_clr = rd_en && (rd_ch == RD_CH_STATUS);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    counter_rd_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt_arr[i]),
      .latch      (latch_we && latch_mask[i]),
      .rd_hit     (rd_en && (rd_ch == 2'(i))),
      .status_clr (status_clr),
      .value      (value[i]),
      .latched    (latched[i]),
      .out        (out[i]),
      .sticky     (sticky[i]),
      .sticky_next(sticky_next[i])
    );
  end

  always_comb begin
    status_word = '0;
    status_word[ST_OUT_LSB    +: NUM_CH] = out;
    status_word[ST_LAT_LSB    +: NUM_CH] = latched;
    status_word[ST_STICKY_LSB +: NUM_CH] = sticky;
  end

  always_comb begin
    rd_word = '0;
    case (rd_ch)
      2'd0:    rd_word = 32'(value[0]);
      2'd1:    rd_word = 32'(value[1]);
      2'd2:    rd_word = 32'(value[2]);
      default: rd_word = status_word;
    endcase
  end

  // Data is zeroed outside the valid pulse so the bus read mux can OR it in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_word : '0;
    end
  end

`ifdef COUNTER_RD_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(sticky_next & irq_mask);
    end
  end
`else
  logic unused_sticky_next;
  assign unused_sticky_next = ^sticky_next;
`endif

endmodule
